axis_pkt_fifo: RTL and testbench

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

---
 rtl/axis_pkt_fifo.sv | 156 +++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with first-word fall-through output. In packet mode, a commit
// pointer holds back words until their packet completes or a release is requested.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_DEPTH = 14,
  parameter int PKT_MODE   = 1
) (
  input  logic                    s_aclk,
  input  logic                    s_areset_n,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  input  logic                    RECE_DONE,
  output logic [ADDR_DEPTH:0]     word_count,
  output logic [ADDR_DEPTH:0]     pkt_count
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int DEPTH      = 1 << ADDR_DEPTH;
  localparam logic [ADDR_DEPTH:0] PTR_ONE  = {{ADDR_DEPTH{1'b0}}, 1'b1};
  localparam logic [ADDR_DEPTH:0] CNT_FULL = {1'b1, {ADDR_DEPTH{1'b0}}};

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH:0] cm_ptr_q, cm_ptr_d;
  logic [ADDR_DEPTH:0] word_cnt_q, word_cnt_d;
  logic [ADDR_DEPTH:0] pkt_cnt_q, pkt_cnt_d;
  logic                cut_thru_q, cut_thru_d;
  logic                run_q, run_d;

  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  stall_s;
  logic [WORD_WIDTH-1:0] rd_word_s;

  // run_q keeps the write side closed until the first edge after reset
  assign s_tready  = run_q && (word_cnt_q != CNT_FULL);
  assign m_tvalid  = (cm_ptr_q != rd_ptr_q);
  assign wr_en_s   = s_tvalid && s_tready;
  assign rd_en_s   = m_tvalid && m_tready;
  assign rd_word_s = mem[rd_ptr_q[ADDR_DEPTH-1:0]];
  // full with nothing committed: an oversize packet would otherwise deadlock
  assign stall_s   = (word_cnt_q == CNT_FULL) && (cm_ptr_q == rd_ptr_q);
  assign word_count = word_cnt_q;
  assign pkt_count  = pkt_cnt_q;

  // Read-side outputs: the head word, forced to zero while nothing is readable
  always_comb begin
    m_tdata = {DATA_WIDTH{1'b0}};
    m_tkeep = {KEEP_WIDTH{1'b0}};
    m_tlast = 1'b0;
    if (m_tvalid) begin
      m_tdata = rd_word_s[WORD_WIDTH-1 -: DATA_WIDTH];
      m_tkeep = rd_word_s[KEEP_WIDTH:1];
      m_tlast = rd_word_s[0];
    end else begin
      m_tdata = {DATA_WIDTH{1'b0}};
      m_tkeep = {KEEP_WIDTH{1'b0}};
      m_tlast = 1'b0;
    end
  end

  // Next-state for pointers, commit logic and occupancy counters
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    cut_thru_d = cut_thru_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    run_d      = 1'b1;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (PKT_MODE == 0) begin
      cm_ptr_d   = wr_ptr_d;
      cut_thru_d = 1'b0;
    end else begin
      if (cut_thru_q || (wr_en_s && s_tlast) || RECE_DONE) begin
        cm_ptr_d = wr_ptr_d;
      end else if (stall_s) begin
        cm_ptr_d = wr_ptr_q;
      end else begin
        cm_ptr_d = cm_ptr_q;
      end
      // the oversize packet stays cut-through until its tlast is written
      if (wr_en_s && s_tlast) begin
        cut_thru_d = 1'b0;
      end else if (stall_s) begin
        cut_thru_d = 1'b1;
      end else begin
        cut_thru_d = cut_thru_q;
      end
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   word_cnt_d = word_cnt_q + PTR_ONE;
      2'b01:   word_cnt_d = word_cnt_q - PTR_ONE;
      default: word_cnt_d = word_cnt_q;
    endcase

    case ({wr_en_s && s_tlast, rd_en_s && m_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge s_aclk or negedge s_areset_n) begin
    if (!s_areset_n) begin
      wr_ptr_q   <= {(ADDR_DEPTH+1){1'b0}};
      rd_ptr_q   <= {(ADDR_DEPTH+1){1'b0}};
      cm_ptr_q   <= {(ADDR_DEPTH+1){1'b0}};
      word_cnt_q <= {(ADDR_DEPTH+1){1'b0}};
      pkt_cnt_q  <= {(ADDR_DEPTH+1){1'b0}};
      cut_thru_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      cut_thru_q <= cut_thru_d;
      run_q      <= run_d;
    end
  end

  // Storage array; contents are only visible through committed pointers
  always_ff @(posedge s_aclk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q[ADDR_DEPTH-1:0]] <= {s_tdata, s_tkeep, s_tlast};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench: instance 0 is store-and-forward, instance 1 is cut-through.
module tb_axis_pkt_fifo;
  logic        clk;
  logic        rst_n;
  logic [15:0] s_tdata  [2];
  logic [1:0]  s_tkeep  [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic        s_tlast  [2];
  logic [15:0] m_tdata  [2];
  logic [1:0]  m_tkeep  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic        m_tlast  [2];
  logic        rece     [2];
  logic [4:0]  wc       [2];
  logic [4:0]  pc       [2];

  logic [18:0] q0[$];
  logic [18:0] q1[$];
  int total = 0;
  int bad   = 0;
  int pops1 = 0;
  int max1  = 0;

  axis_pkt_fifo #(.DATA_WIDTH(16), .ADDR_DEPTH(4), .PKT_MODE(1)) u_sf (
    .s_aclk(clk), .s_areset_n(rst_n),
    .s_tdata(s_tdata[0]), .s_tkeep(s_tkeep[0]), .s_tvalid(s_tvalid[0]),
    .s_tready(s_tready[0]), .s_tlast(s_tlast[0]),
    .m_tdata(m_tdata[0]), .m_tkeep(m_tkeep[0]), .m_tvalid(m_tvalid[0]),
    .m_tready(m_tready[0]), .m_tlast(m_tlast[0]),
    .RECE_DONE(rece[0]), .word_count(wc[0]), .pkt_count(pc[0]));

  axis_pkt_fifo #(.DATA_WIDTH(16), .ADDR_DEPTH(4), .PKT_MODE(0)) u_ct (
    .s_aclk(clk), .s_areset_n(rst_n),
    .s_tdata(s_tdata[1]), .s_tkeep(s_tkeep[1]), .s_tvalid(s_tvalid[1]),
    .s_tready(s_tready[1]), .s_tlast(s_tlast[1]),
    .m_tdata(m_tdata[1]), .m_tkeep(m_tkeep[1]), .m_tvalid(m_tvalid[1]),
    .m_tready(m_tready[1]), .m_tlast(m_tlast[1]),
    .RECE_DONE(rece[1]), .word_count(wc[1]), .pkt_count(pc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] keep_of(input logic [15:0] d);
    return d[0] ? 2'b01 : 2'b11;
  endfunction

  // drive one word, wait for acceptance, optionally record it as expected output
  task automatic wr(input int u, input logic [15:0] d, input logic l, input bit push);
    int n;
    n = 0;
    s_tvalid[u] = 1'b1; s_tdata[u] = d; s_tkeep[u] = keep_of(d); s_tlast[u] = l;
    forever begin
      @(negedge clk);
      if (s_tready[u]) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL wr_timeout: inst %0d word %0h never accepted", u, d);
        break;
      end
      @(posedge clk); #1;
    end
    if (push) begin
      if (u == 0) q0.push_back({d, keep_of(d), l});
      else        q1.push_back({d, keep_of(d), l});
    end
    @(posedge clk); #1;
    s_tvalid[u] = 1'b0;
  endtask

  // monitor for the store-and-forward instance
  always @(negedge clk) begin
    if (rst_n && m_tvalid[0]) begin
      if (q0.size() == 0) begin
        chk("sf_unexpected", {m_tdata[0], m_tkeep[0], m_tlast[0]}, 32'h7FFFF);
      end else if (m_tready[0]) begin
        chk("sf_out", {m_tdata[0], m_tkeep[0], m_tlast[0]}, q0.pop_front());
      end else begin
        chk("sf_hold", {m_tdata[0], m_tkeep[0], m_tlast[0]}, q0[0]);
      end
    end
  end

  // monitor for the cut-through instance, also tracks peak occupancy
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(wc[1]) > max1) max1 = int'(wc[1]);
      if (m_tvalid[1]) begin
        if (q1.size() == 0) begin
          chk("ct_unexpected", {m_tdata[1], m_tkeep[1], m_tlast[1]}, 32'h7FFFF);
        end else if (m_tready[1]) begin
          chk("ct_out", {m_tdata[1], m_tkeep[1], m_tlast[1]}, q1.pop_front());
          pops1++;
        end else begin
          chk("ct_hold", {m_tdata[1], m_tkeep[1], m_tlast[1]}, q1[0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      s_tdata[u] = 16'h0; s_tkeep[u] = 2'b00; s_tvalid[u] = 1'b0;
      s_tlast[u] = 1'b0; m_tready[u] = 1'b0; rece[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_wc", wc[0], 0);
    chk("rst_pc", pc[0], 0);
    chk("rst_ready", s_tready[0], 0);
    chk("rst_mvalid", m_tvalid[0], 0);
    chk("rst_mlast", m_tlast[0], 0);
    chk("rst_mdata", {m_tdata[0], m_tkeep[0]}, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready_low", s_tready[0], 0);
    @(posedge clk); #1;
    chk("rel_ready_high", s_tready[0], 1);

    // store-and-forward: held until tlast
    m_tready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr(0, 16'(i), i == 4, 1'b1);
      if (i < 4) chk("sf_held", m_tvalid[0], 0);
    end
    chk("sf_release", m_tvalid[0], 1);
    chk("sf_pc1", pc[0], 1);
    repeat (10) @(posedge clk);
    #1 chk("sf_pc0", pc[0], 0);
    chk("sf_drain", q0.size(), 0);

    // explicit release of a packet with no tlast
    for (int i = 0; i < 8; i++) wr(0, 16'h0010 + 16'(i), 1'b0, 1'b1);
    chk("rd_held", m_tvalid[0], 0);
    rece[0] = 1'b1;
    @(negedge clk);
    chk("rd_not_yet", m_tvalid[0], 0);
    @(posedge clk); #1;
    rece[0] = 1'b0;
    chk("rd_release", m_tvalid[0], 1);
    repeat (12) @(posedge clk);
    #1 chk("rd_drain", q0.size(), 0);

    // oversize packet fallback
    m_tready[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) wr(0, 16'h0100 + 16'(i), i == 19, 1'b1);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (wc[0] != 5'd16 && n < 300);
        chk("ov_full_wc", wc[0], 16);
        chk("ov_ready_low", s_tready[0], 0);
        @(negedge clk);
        chk("ov_fallback", m_tvalid[0], 1);
        @(posedge clk); #1;
        m_tready[0] = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    #1 chk("ov_drain", q0.size(), 0);
    chk("ov_wc0", wc[0], 0);
    chk("ov_pc0", pc[0], 0);

    // cut-through: latency, no bypass, streaming through a full buffer
    m_tready[1] = 1'b0;
    s_tvalid[1] = 1'b1; s_tdata[1] = 16'h0A00; s_tkeep[1] = keep_of(16'h0A00); s_tlast[1] = 1'b0;
    @(negedge clk);
    chk("ct_no_bypass_v", m_tvalid[1], 0);
    chk("ct_no_bypass_d", m_tdata[1], 0);
    q1.push_back({16'h0A00, keep_of(16'h0A00), 1'b0});
    @(posedge clk); #1;
    s_tvalid[1] = 1'b0;
    chk("ct_lat_v", m_tvalid[1], 1);
    chk("ct_lat_d", m_tdata[1], 16'h0A00);
    pops1 = 0;
    max1 = 0;
    fork
      begin
        for (int i = 1; i < 40; i++) wr(1, 16'h0A00 + 16'(i), (i % 8) == 7, 1'b1);
      end
      begin
        for (int c = 0; c < 400 && pops1 < 40; c++) begin
          m_tready[1] = ~m_tready[1];
          @(posedge clk); #1;
        end
        m_tready[1] = 1'b0;
      end
    join
    chk("ct_count", pops1, 40);
    chk("ct_peak", max1, 16);
    chk("ct_pc0", pc[1], 0);

    // simultaneous write and read, then reset with stored words
    for (int i = 0; i < 7; i++) wr(1, 16'h0200 + 16'(i), 1'b0, 1'b1);
    chk("sim_wc7a", wc[1], 7);
    m_tready[1] = 1'b1;
    wr(1, 16'h0207, 1'b0, 1'b1);
    m_tready[1] = 1'b0;
    chk("sim_wc7b", wc[1], 7);
    m_tready[1] = 1'b1;
    @(posedge clk); #1;
    m_tready[1] = 1'b0;
    chk("pre_rst_wc6", wc[1], 6);
    for (int i = 0; i < 3; i++) wr(0, 16'h0300 + 16'(i), 1'b0, 1'b0);
    chk("partial_wc3", wc[0], 3);
    rst_n = 1'b0;
    #1;
    chk("arst_wc", wc[1], 0);
    chk("arst_mvalid", m_tvalid[1], 0);
    chk("arst_ready", s_tready[1], 0);
    chk("arst_partial", wc[0], 0);
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr(1, 16'h5A5A, 1'b1, 1'b1);
    chk("post_rst_v", m_tvalid[1], 1);
    chk("post_rst_d", m_tdata[1], 16'h5A5A);
    m_tready[1] = 1'b1;
    m_tready[0] = 1'b1;
    wr(0, 16'h0400, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1 chk("end_q0", q0.size(), 0);
    chk("end_q1", q1.size(), 0);
    chk("end_wc0", wc[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
